// File: rtl/mem_wb_writeback_pkg.sv
// Shared MIPS definitions: load-type codes and the hard-wired zero register.
package mips_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LB  = 3'd1,
    LBU = 3'd2,
    LH  = 3'd3,
    LHU = 3'd4
  } load_type_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int unsigned XLEN = 32;

endpackage

// File: rtl/mem_wb_writeback_if.sv
// Connection between a load-data consumer (master) and the load_extract unit (slave).
interface mem_wb_writeback_if;
  logic [31:0] mem_data;
  logic [1:0]  off;
  logic [2:0]  load_type;
  logic [31:0] data;
  logic        misaligned;

  modport master (output mem_data, off, load_type, input  data, misaligned);
  modport slave  (input  mem_data, off, load_type, output data, misaligned);
endinterface

// File: rtl/mem_wb_writeback_load_extract.sv
// Combinational big-endian sub-word extraction with sign/zero extension and
// alignment detection; codes outside the defined set behave as LW.
module load_extract
  import mips_pkg::*;
(
  mem_wb_writeback_if.slave ext
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane 0 is the most significant byte/halfword of the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign byte_lane[gi] = ext.mem_data[31 - 8*gi -: 8];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_lane[gi] = ext.mem_data[31 - 16*gi -: 16];
  end

  assign sel_byte = byte_lane[ext.off];
  assign sel_half = half_lane[ext.off[1]];

  always_comb begin
    ext.data       = ext.mem_data;
    ext.misaligned = 1'b0;
    case (ext.load_type)
      LB:  ext.data = {{24{sel_byte[7]}}, sel_byte};
      LBU: ext.data = {24'd0, sel_byte};
      LH: begin
        ext.data       = {{16{sel_half[15]}}, sel_half};
        ext.misaligned = ext.off[0];
      end
      LHU: begin
        ext.data       = {16'd0, sel_half};
        ext.misaligned = ext.off[0];
      end
      default: ext.misaligned = (ext.off != 2'd0);
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB stage register plus writeback: result select, register-file write
// enable, forwarding tap and retired-instruction counter.
module mem_wb_writeback
  import mips_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_reg_write,
  input  logic                 in_mem_to_reg,
  input  logic [2:0]           in_load_type,
  input  logic [4:0]           in_rd,
  input  logic [WIDTH-1:0]     in_alu_result,
  input  logic [WIDTH-1:0]     in_mem_data,
  output logic [4:0]           rd,
  output logic [WIDTH-1:0]     write_data,
  output logic                 regWrite,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [WIDTH-1:0]     fwd_data,
  output logic                 align_err,
  output logic [CNT_WIDTH-1:0] retired
);

  logic                 valid_q, valid_d;
  logic                 reg_write_q, reg_write_d;
  logic                 mem_to_reg_q, mem_to_reg_d;
  logic [2:0]           load_type_q, load_type_d;
  logic [4:0]           rd_q, rd_d;
  logic [WIDTH-1:0]     alu_q, alu_d;
  logic [WIDTH-1:0]     mem_q, mem_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  mem_wb_writeback_if ext_if ();
  load_extract u_load_extract (.ext(ext_if.slave));

  assign ext_if.mem_data  = mem_q;
  assign ext_if.off       = alu_q[1:0];
  assign ext_if.load_type = load_type_q;

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    load_type_d  = load_type_q;
    rd_d         = rd_q;
    alu_d        = alu_q;
    mem_d        = mem_q;
    retired_d    = retired_q;
    // The held instruction leaves the stage whenever it is not stalled.
    if (valid_q && !stall) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d      = in_valid;
      reg_write_d  = in_reg_write;
      mem_to_reg_d = in_mem_to_reg;
      load_type_d  = in_load_type;
      rd_d         = in_rd;
      alu_d        = in_alu_result;
      mem_d        = in_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_type_q  <= 3'd0;
      rd_q         <= REG_ZERO;
      alu_q        <= '0;
      mem_q        <= '0;
      retired_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      load_type_q  <= load_type_d;
      rd_q         <= rd_d;
      alu_q        <= alu_d;
      mem_q        <= mem_d;
      retired_q    <= retired_d;
    end
  end

  assign align_err  = valid_q & mem_to_reg_q & ext_if.misaligned;
  assign write_data = mem_to_reg_q ? ext_if.data : alu_q;
  assign regWrite   = valid_q & reg_write_q & (rd_q != REG_ZERO) & ~align_err;
  assign rd         = rd_q;
  assign fwd_valid  = regWrite;
  assign fwd_rd     = rd_q;
  assign fwd_data   = write_data;
  assign retired    = retired_q;

endmodule
